// File: rtl/calc_pkg.sv
// Shared opcode constants, FSM state encoding and default width for the
// calc_op_seq operation sequencer and its divider.
package calc_pkg;

    localparam int CALC_WIDTH = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle. The caller owns the
// iteration count and flags the final step with 'last'.
module div_iter
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             last,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             div_zero
);

    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] work_nx;

    // A clear top bit of diff means no borrow: the divisor fits, keep the difference.
    // A zero divisor always fits, which yields the all-ones quotient by itself.
    always_comb begin
        rem_sh  = {rem, work_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs};
        q_bit   = ~diff[WIDTH];
        rem_nx  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        work_nx = {work_q[WIDTH-2:0], q_bit};
    end

    assign done = busy && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            work_q   <= '0;
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            div_zero <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            work_q   <= dividend;
            rem      <= '0;
            dvs      <= divisor;
            div_zero <= (divisor == '0);
        end else if (busy) begin
            work_q <= work_nx;
            rem    <= rem_nx;
            if (last) begin
                busy     <= 1'b0;
                quotient <= work_nx;
            end
        end
    end

endmodule

// File: rtl/calc_op_seq.sv
// Single-request arithmetic sequencer: registers operands on accept, exposes all
// four results to a downstream 4:1 mux and handshakes the selected one out.
module calc_op_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       opcode,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] res_add,
    output logic [WIDTH-1:0] res_sub,
    output logic [WIDTH-1:0] res_mul,
    output logic [WIDTH-1:0] res_div,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             div_by_zero
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] cnt;
    logic             dbz_r;
    logic             accept;
    logic             div_start;
    logic             div_last;
    logic             div_busy;
    logic             div_done;
    logic             div_zero;

    assign accept    = in_valid && in_ready;
    assign div_start = accept && (opcode == OP_DIV);
    assign div_last  = (state == ST_DIV) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = (opcode == OP_DIV) ? ST_DIV : ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operands and opcode only move on accept, so busy-time requests cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= OP_ADD;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else if (accept) begin
            a_r   <= op_a;
            b_r   <= op_b;
            op_r  <= opcode;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else begin
            if (div_busy) begin
                cnt <= div_last ? '0 : cnt + 1'b1;
            end
            if (div_done) begin
                dbz_r <= div_zero;
            end
        end
    end

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .last     (div_last),
        .dividend (op_a),
        .divisor  (op_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (res_div),
        .div_zero (div_zero)
    );

    assign sel         = op_r;
    assign res_add     = a_r + b_r;
    assign res_sub     = a_r - b_r;
    assign res_mul     = a_r * b_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_calc_op_seq.sv
// Testbench for calc_op_seq: vector table driven through a scoreboard queue,
// plus hand-written reset and reset-during-divide sequences.
module tb_calc_op_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   opcode;
    logic [1:0]   sel;
    logic [W-1:0] res_add;
    logic [W-1:0] res_sub;
    logic [W-1:0] res_mul;
    logic [W-1:0] res_div;
    logic         out_valid;
    logic         out_ready;
    logic         div_by_zero;

    calc_op_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .opcode      (opcode),
        .sel         (sel),
        .res_add     (res_add),
        .res_sub     (res_sub),
        .res_mul     (res_mul),
        .res_div     (res_div),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        int           hold;
        bit           noise;
        logic [W-1:0] res;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after completion.
    task automatic run_op(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   lat;
        int   guard;
        logic [W-1:0] bus;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d in_ready before accept", idx), W'(in_ready), W'(1));
        op_a      = v.a;
        op_b      = v.b;
        opcode    = v.op;
        in_valid  = 1'b1;
        out_ready = (v.hold == 0);
        e.op  = v.op;
        e.res = v.res;
        e.dbz = v.dbz;
        e.lat = (v.op == 2'b11) ? W + 1 : 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (v.noise) begin
                in_valid = 1'($urandom_range(0, 1));
                op_a     = $urandom;
                op_b     = $urandom;
                opcode   = 2'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check($sformatf("v%0d out_valid seen", idx), W'(out_valid), W'(1));
        got = sb.pop_front();
        check($sformatf("v%0d latency", idx), W'(lat), W'(got.lat));
        check($sformatf("v%0d sel", idx), W'(sel), W'(got.op));
        case (got.op)
            2'b00:   bus = res_add;
            2'b01:   bus = res_sub;
            2'b10:   bus = res_mul;
            default: bus = res_div;
        endcase
        check($sformatf("v%0d result", idx), bus, got.res);
        check($sformatf("v%0d div_by_zero", idx), W'(div_by_zero), W'(got.dbz));
        for (int h = 0; h < v.hold; h++) begin
            check($sformatf("v%0d held out_valid", idx), W'(out_valid), W'(1));
            check($sformatf("v%0d held in_ready", idx), W'(in_ready), W'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d out_valid after handshake", idx), W'(out_valid), W'(0));
        check($sformatf("v%0d in_ready after handshake", idx), W'(in_ready), W'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, W'(in_ready), W'(1));
        check({tag, " out_valid"}, W'(out_valid), W'(0));
        check({tag, " sel"}, W'(sel), W'(0));
        check({tag, " res_add"}, res_add, '0);
        check({tag, " res_sub"}, res_sub, '0);
        check({tag, " res_mul"}, res_mul, '0);
        check({tag, " res_div"}, res_div, '0);
        check({tag, " div_by_zero"}, W'(div_by_zero), W'(0));
    endtask

    initial begin
        int seen;
        //          a             b             op     hold noise res           dbz
        vecs[0]  = '{32'd7,        32'd5,        2'b00, 0, 1'b0, 32'd12,       1'b0};
        vecs[1]  = '{32'd3,        32'd5,        2'b01, 0, 1'b0, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{32'h00010000, 32'h00010000, 2'b10, 5, 1'b0, 32'd0,        1'b0};
        vecs[3]  = '{32'd100,      32'd7,        2'b11, 0, 1'b1, 32'd14,       1'b0};
        vecs[4]  = '{32'd9,        32'd0,        2'b11, 0, 1'b0, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{32'd1,        32'd2,        2'b00, 0, 1'b0, 32'd3,        1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'd1,        2'b00, 0, 1'b0, 32'd0,        1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 2, 1'b0, 32'd1,        1'b0};
        vecs[8]  = '{32'd5,        32'd9,        2'b11, 0, 1'b0, 32'd0,        1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'd1,        2'b11, 0, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{32'h80000000, 32'd3,        2'b11, 0, 1'b0, 32'h2AAAAAAA, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        opcode    = 2'b00;

        @(negedge clk);
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", W'(in_ready), W'(1));

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], i);
        end

        // Reset asserted between clock edges partway through a divide.
        op_a      = 32'd100;
        op_b      = 32'd7;
        opcode    = 2'b11;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid-div busy", W'(in_ready), W'(0));
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-div reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no out_valid after abandoned divide", W'(seen), W'(0));

        run_op('{32'd20, 32'd22, 2'b00, 0, 1'b0, 32'd42, 1'b0}, 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/calc_op_seq.md
CALC_OP_SEQ -- requirements
Module: calc_op_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous active-low reset).
REQ-002 Parameter WIDTH, default 32: operand and result width in bits.
REQ-003 in_valid, input, 1 bit: request present.
REQ-004 in_ready, output, 1 bit: block can accept a request.
REQ-005 op_a, input, WIDTH bits: first operand, unsigned.
REQ-006 op_b, input, WIDTH bits: second operand, unsigned.
REQ-007 opcode, input, 2 bits: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 sel, output, 2 bits: selector for the downstream 4:1 result mux.
REQ-009 res_add, res_sub, res_mul, res_div, outputs, WIDTH bits each: the mux data inputs for codes 00, 01, 10 and 11.
REQ-010 out_valid, output, 1 bit: the selected result is final.
REQ-011 out_ready, input, 1 bit: the consumer takes the result.
REQ-012 div_by_zero, output, 1 bit: the current division had op_b equal to 0.

Function
REQ-013 States SHALL be IDLE, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept occurs on a rising edge with in_valid and in_ready both high; op_a, op_b and opcode SHALL then be registered.
REQ-015 On accept, the next state SHALL be DIV if opcode is 11, else DONE.
REQ-016 sel SHALL equal the registered opcode, held stable from accept until the next accept.
REQ-017 res_add SHALL be (a+b) mod 2^WIDTH, combinational from registered operands; carry discarded.
REQ-018 res_sub SHALL be (a-b) mod 2^WIDTH; borrow discarded.
REQ-019 res_mul SHALL be the low WIDTH bits of a*b.
REQ-020 res_div SHALL be a registered quotient from an unsigned restoring divider taking exactly WIDTH cycles in DIV; it SHALL hold its value outside DIV.
REQ-021 DIV SHALL use an iteration counter 0..WIDTH-1 and go to DONE on the cycle the counter reaches WIDTH-1.
REQ-022 Latency: out_valid SHALL be 1 in the cycle after accept for opcodes 00-10, and WIDTH+1 cycles after accept for 11.
REQ-023 out_valid SHALL be 1 only in DONE; DONE SHALL hold while out_ready is 0, and go to IDLE on a rising edge with out_ready 1.
REQ-024 Back-to-back: a new accept SHALL be possible in the cycle after a DONE completion, with no bubble beyond the IDLE cycle.
REQ-025 Divide by zero: the DIV state SHALL still take WIDTH cycles, res_div SHALL be all ones, and div_by_zero SHALL be 1 while in DONE; div_by_zero SHALL be cleared on the next accept.
REQ-026 in_valid while the block is busy SHALL be ignored; the registered operands SHALL not change.
REQ-027 out_ready while the block is not in DONE SHALL have no effect.

Reset
REQ-028 On rst_n low, regardless of clk, the block SHALL immediately set state IDLE, operands 0, opcode 00, res_div 0, counter 0 and div_by_zero 0.
REQ-029 The reset outputs SHALL therefore be in_ready 1, out_valid 0, sel 00, and all result buses 0.
REQ-030 Reset mid-DIV or mid-DONE SHALL abandon the operation with no out_valid pulse afterwards.
REQ-031 The first accept after rst_n rises SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-032 A shared package calc_pkg SHALL hold the opcode constants OP_ADD, OP_SUB, OP_MUL and OP_DIV, the state encoding, and the default WIDTH.
REQ-033 The restoring divider SHALL be a sub-module div_iter, with start/busy/done, the quotient and a zero flag; sequencing SHALL stay in calc_op_seq.
REQ-034 sel and the res_* buses SHALL connect directly to the downstream 4:1 mux with no additional logic.

Verification
REQ-035 Reset then add: a=7, b=5, opcode 00, out_ready 1 -> in_ready 1 after reset, then in the cycle after accept sel=00, res_add=12 and out_valid=1.
REQ-036 Sub wrap: a=3, b=5, opcode 01 -> res_sub=0xFFFFFFFE, sel=01, out_valid one cycle after accept.
REQ-037 Mul truncation and backpressure: a=0x10000, b=0x10000, opcode 10, out_ready held 0 for 5 cycles -> res_mul=0 and out_valid held for 5 cycles; in_ready stays 0 until out_ready rises.
REQ-038 Divide: a=100, b=7, opcode 11 -> out_valid exactly 33 cycles after accept, res_div=14, div_by_zero=0; in_valid pulses during DIV are ignored.
REQ-039 Divide by zero then add: a=9, b=0, opcode 11 -> after 33 cycles res_div=0xFFFFFFFF and div_by_zero=1; the following add clears div_by_zero.
REQ-040 Reset mid-division: rst_n low at cycle 10 of DIV -> all outputs at reset values immediately, and no out_valid for 40 following cycles with in_valid low.
